// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : regfile_pkg

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot arbiter with pointer advance
module rr_arbiter #(
    parameter int N = 2,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] grant_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;

    // Pick the first requester after the pointer, wrapping; the winner becomes the next pointer
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && (PTR_W'(i) > ptr_q)) begin
                grant_o[i] = 1'b1;
                ptr_d      = PTR_W'(i);
                found      = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req_i[i]) begin
                grant_o[i] = 1'b1;
                ptr_d      = PTR_W'(i);
                found      = 1'b1;
            end
        end
    end

    // Pointer starts at the last index so requester 0 wins first after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PTR_W'(N - 1);
        end else if (advance_i && found) begin
            ptr_q <= ptr_d;
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register bank write port among writeback sources
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*ADDR_W-1:0] req_rd,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_rd,
    output logic [DATA_W-1:0]       wr_data,
    output logic [(2**ADDR_W)-1:0]  busy_vec,
    output logic [CNT_W-1:0]        wr_count
);

    localparam int NREG = 2**ADDR_W;

    logic [N_REQ-1:0]  grant;
    logic              xfer;
    logic [ADDR_W-1:0] sel_rd;
    logic [DATA_W-1:0] sel_data;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_rd_q, wr_rd_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_valid),
        .advance_i (xfer),
        .grant_o   (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    // One-hot mux of the granted requester's destination and data
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = sel_rd   | req_rd[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next output slot: writes to x0 are accepted but never reach the bank or the counter
    always_comb begin
        wr_en_d   = xfer && (sel_rd != ADDR_W'(REG_ZERO));
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;
        cnt_d     = cnt_q;
        if (wr_en_d) begin
            wr_rd_d   = sel_rd;
            wr_data_d = sel_data;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output register stage; reset drops any captured but unissued write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
            cnt_q     <= cnt_d;
        end
    end

    // Pending-write map: waiting requests plus the write on the port this cycle; x0 never busy
    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && (req_rd[i*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
                    busy_vec[r] = 1'b1;
                end
            end
            if (wr_en_q && (wr_rd_q == ADDR_W'(r))) begin
                busy_vec[r] = 1'b1;
            end
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_rd    = wr_rd_q;
    assign wr_data  = wr_data_q;
    assign wr_count = cnt_q;

endmodule : regfile_wb_arbiter
